bcd_attempt_counter_n: RTL and testbench
========================================

Name: bcd_attempt_counter_n

Overview:
- Parametrised N-digit BCD event counter with per-digit active-low seven-segment decode. Successor to the fixed two-digit attempt counter.
- Adds a selectable wrap or saturate mode, a sticky overflow flag, and a best-run (minimum count at win) register with a display mux.
- Sits beside the level logic. It counts player deaths (attempts) on game_clk and drives HEX displays and LEDs.

Parameters:
- DIGITS, 2, number of BCD digits (1..8); max count = 10^DIGITS - 1.
- SATURATE, 0, 0 = wrap all-9s -> 0; 1 = hold at all-9s.
- TRACK_BEST, 1, 1 = best-run register implemented; 0 = best outputs tied to 0, best_valid = 0.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; clears all state.
- inc  in  1  count one event this cycle.
- win  in  1  end-of-run strobe: capture best, clear count.
- show_best  in  1  0 = segments show count; 1 = segments show best.
- count  out  4*DIGITS  packed BCD count; digit 0 = [3:0] (ones).
- best  out  4*DIGITS  packed BCD best (lowest) count captured at win.
- best_valid  out  1  best holds a captured value.
- carry_out  out  1  one-cycle pulse when count wraps all-9s -> 0 (SATURATE=0 only).
- overflow  out  1  sticky: inc was seen while count = all-9s.
- seg  out  7*DIGITS  active-low segments gfedcba per digit; digit i = [7i+6:7i].

Behaviour:
- Reset (synchronous, highest priority): count = 0, best = 0, best_valid = 0, carry_out = 0, overflow = 0.
- Priority per cycle: reset > win > inc. Inc is ignored in a cycle where win = 1.
- Inc, count below all-9s:
  - Digit 0 increments.
  - Any digit reaching 9 with an incoming carry becomes 0 and carries to the next digit (ripple within one cycle).
  - The new value is visible one cycle after the inc edge.
  - Every digit always stays in 0..9.
- Inc at all-9s, SATURATE=0: count -> 0, carry_out = 1 for exactly that one cycle, overflow <= 1.
- Inc at all-9s, SATURATE=1: count holds, carry_out stays 0, overflow <= 1.
- carry_out is 0 in every other cycle, and never asserts on a non-wrap increment.
- Win:
  - Compare uses the count value before this edge. A packed-BCD unsigned compare equals a numeric compare.
  - If overflow = 0 and (best_valid = 0 or count < best): best <= count, best_valid <= 1.
  - If overflow = 1, best is not updated, because the overflowed count is invalid.
  - Then count <= 0 and overflow <= 0. best and best_valid persist.
- Win with count = best: no update (strict less-than).
- Win with count = 0 is a legal capture (best may become 0).
- TRACK_BEST = 0: best and best_valid are constant 0; win only clears count and overflow.
- seg is combinational from registered count or best, selected by show_best.
  - Codes: 0:1000000, 1:1111001, 2:0100100, 3:0110000, 4:0011001, 5:0010010, 6:0000010, 7:1111000, 8:0000000, 9:0011000.
  - Non-BCD codes are unreachable but decode to 1111111 (blank), never X.
- show_best = 1 with best_valid = 0: all digits show blank (1111111).
- Reset mid-operation (any state, including with win/inc asserted): the reset state applies next cycle; inc and win are ignored that cycle.
- No X on any output after the first reset edge. Outputs before the first reset are don't-care.

Test Plan:
- DIGITS=2, SATURATE=0: reset, then 99 inc pulses -> count=0x99, seg[6:0]=0011000, seg[13:7]=0011000; 100th inc -> count=0x00, carry_out high exactly 1 cycle, overflow=1.
- DIGITS=2, SATURATE=1: 105 incs -> count holds 0x99 from the 99th inc, carry_out never asserts, overflow=1. Then win -> count=0x00, overflow=0, best_valid=0.
- Best tracking:
  - 12 incs then win -> best=0x12, best_valid=1, count=0.
  - 15 incs then win -> best stays 0x12.
  - 7 incs then win -> best=0x07.
  - 7 incs then win -> best stays 0x07.
- Priority: count=0x05, assert inc and win in the same cycle -> count=0x00, best=0x05 (pre-edge value). Reset asserted with inc -> count=0x00, best_valid=0.
- Display mux:
  - show_best=1 before any win -> seg all 1s.
  - After best=0x07 -> seg[6:0]=1111000, seg[13:7]=1000000.
  - show_best=0 -> shows the live count.
- DIGITS=4: 999 incs -> count=0x0999; next inc -> 0x1000 in one cycle (triple ripple). TRACK_BEST=0 -> best=0 and best_valid=0 throughout.

Source files
------------

// File: rtl/bcd_attempt_counter_n.sv
// ============================================================================
// Module   : bcd_attempt_counter_n
// Brief    : N-digit BCD attempt counter with wrap/saturate, sticky overflow,
//            best-run capture and active-low seven-segment display mux.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_attempt_counter_n #(
    parameter int DIGITS     = 2,
    parameter int SATURATE   = 0,
    parameter int TRACK_BEST = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc,
    input  logic                  win,
    input  logic                  show_best,
    output logic [4*DIGITS-1:0]   count,
    output logic [4*DIGITS-1:0]   best,
    output logic                  best_valid,
    output logic                  carry_out,
    output logic                  overflow,
    output logic [7*DIGITS-1:0]   seg
);

    localparam int             W       = 4 * DIGITS;
    localparam logic [W-1:0]   C_ALL9  = {DIGITS{4'h9}};
    localparam logic [6:0]     C_BLANK = 7'b1111111;

    logic [W-1:0] count_q, count_d;
    logic [W-1:0] inc_val;
    logic         rip;
    logic         carry_q, carry_d;
    logic         ovf_q, ovf_d;
    logic         at_max;

    assign at_max = (count_q == C_ALL9);

    // Decimal ripple: each digit at 9 rolls to 0 and passes the carry upward.
    always_comb begin
        inc_val = count_q;
        rip     = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (rip) begin
                if (count_q[4*i +: 4] >= 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    rip               = 1'b0;
                end
            end
        end
    end

    always_comb begin
        count_d = count_q;
        carry_d = 1'b0;
        ovf_d   = ovf_q;
        if (win) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (inc) begin
            if (at_max) begin
                ovf_d = 1'b1;
                if (SATURATE == 0) begin
                    count_d = '0;
                    carry_d = 1'b1;
                end
            end else begin
                count_d = inc_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count     = count_q;
    assign carry_out = carry_q;
    assign overflow  = ovf_q;

    generate
        if (TRACK_BEST != 0) begin : g_best
            logic [W-1:0] best_q, best_d;
            logic         best_valid_q, best_valid_d;

            // An overflowed run is not a real score, so it never becomes best.
            always_comb begin
                best_d       = best_q;
                best_valid_d = best_valid_q;
                if (win && !ovf_q && (!best_valid_q || (count_q < best_q))) begin
                    best_d       = count_q;
                    best_valid_d = 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    best_q       <= '0;
                    best_valid_q <= 1'b0;
                end else begin
                    best_q       <= best_d;
                    best_valid_q <= best_valid_d;
                end
            end

            assign best       = best_q;
            assign best_valid = best_valid_q;
        end else begin : g_no_best
            assign best       = '0;
            assign best_valid = 1'b0;
        end
    endgenerate

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0011000;
            default: seg7 = C_BLANK;
        endcase
    endfunction

    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_seg
            logic [3:0] w_digit;
            logic       w_blank;
            assign w_blank        = show_best && !best_valid;
            assign w_digit        = show_best ? best[4*i +: 4] : count_q[4*i +: 4];
            assign seg[7*i +: 7]  = w_blank ? C_BLANK : seg7(w_digit);
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_bcd_attempt_counter_n.sv
// ============================================================================
// Module   : tb_bcd_attempt_counter_n
// Brief    : Directed self-checking bench for bcd_attempt_counter_n.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_attempt_counter_n;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S9 = 7'b0011000;
    localparam logic [6:0] SB = 7'b1111111;

    logic clk = 1'b0;
    logic reset, show_best;
    logic a_inc, a_win, b_inc, b_win, c_inc, c_win;

    logic [7:0]  a_count, a_best, b_count, b_best;
    logic [15:0] c_count, c_best;
    logic [13:0] a_seg, b_seg;
    logic [27:0] c_seg;
    logic a_bv, a_co, a_ovf, b_bv, b_co, b_ovf, c_bv, c_co, c_ovf;

    int n_checks = 0;
    int n_fail   = 0;
    logic seen;

    always #5 clk = ~clk;

    bcd_attempt_counter_n #(.DIGITS(2), .SATURATE(0), .TRACK_BEST(1)) u_a (
        .clk(clk), .reset(reset), .inc(a_inc), .win(a_win), .show_best(show_best),
        .count(a_count), .best(a_best), .best_valid(a_bv), .carry_out(a_co),
        .overflow(a_ovf), .seg(a_seg));

    bcd_attempt_counter_n #(.DIGITS(2), .SATURATE(1), .TRACK_BEST(1)) u_b (
        .clk(clk), .reset(reset), .inc(b_inc), .win(b_win), .show_best(show_best),
        .count(b_count), .best(b_best), .best_valid(b_bv), .carry_out(b_co),
        .overflow(b_ovf), .seg(b_seg));

    bcd_attempt_counter_n #(.DIGITS(4), .SATURATE(0), .TRACK_BEST(0)) u_c (
        .clk(clk), .reset(reset), .inc(c_inc), .win(c_win), .show_best(show_best),
        .count(c_count), .best(c_best), .best_valid(c_bv), .carry_out(c_co),
        .overflow(c_ovf), .seg(c_seg));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic a_pulses(input int n);
        a_inc = 1'b1;
        repeat (n) tick();
        a_inc = 1'b0;
    endtask

    task automatic a_winp();
        a_win = 1'b1;
        tick();
        a_win = 1'b0;
    endtask

    initial begin
        reset = 1'b1; show_best = 1'b0;
        a_inc = 1'b0; a_win = 1'b0; b_inc = 1'b0; b_win = 1'b0; c_inc = 1'b0; c_win = 1'b0;
        tick(); tick();
        reset = 1'b0;

        check("rst_count",   a_count, 64'h00);
        check("rst_best",    a_best,  64'h00);
        check("rst_bv",      a_bv,    64'h0);
        check("rst_carry",   a_co,    64'h0);
        check("rst_ovf",     a_ovf,   64'h0);
        check("rst_seg",     a_seg,   {S0, S0});
        check("rst_c_count", c_count, 64'h0000);

        show_best = 1'b1; #1;
        check("seg_best_blank", a_seg, {SB, SB});
        show_best = 1'b0; #1;

        // Wrap mode: 99 -> 0 with a one-cycle carry pulse
        a_pulses(99);
        check("a_99_count", a_count, 64'h99);
        check("a_99_seg",   a_seg,   {S9, S9});
        check("a_99_ovf",   a_ovf,   64'h0);
        check("a_99_carry", a_co,    64'h0);
        a_pulses(1);
        check("a_wrap_count", a_count, 64'h00);
        check("a_wrap_carry", a_co,    64'h1);
        check("a_wrap_ovf",   a_ovf,   64'h1);
        tick();
        check("a_carry_1cyc", a_co,  64'h0);
        check("a_ovf_sticky", a_ovf, 64'h1);
        a_winp();
        check("a_ovfwin_ovf", a_ovf, 64'h0);
        check("a_ovfwin_bv",  a_bv,  64'h0);

        // Best tracking
        a_pulses(12); a_winp();
        check("best12",       a_best,  64'h12);
        check("best12_bv",    a_bv,    64'h1);
        check("best12_count", a_count, 64'h00);
        a_pulses(15); a_winp();
        check("best15_keep",  a_best,  64'h12);
        a_pulses(7); a_winp();
        check("best07",       a_best,  64'h07);
        show_best = 1'b1; #1;
        check("seg_best07",   a_seg,   {S0, S7});
        show_best = 1'b0; #1;
        a_pulses(3);
        check("seg_live3",    a_seg,   {S0, S3});
        a_pulses(4); a_winp();
        check("best_equal_keep", a_best, 64'h07);

        // Priority: win beats inc, capture uses pre-edge count
        a_pulses(5);
        a_inc = 1'b1; a_win = 1'b1;
        tick();
        a_inc = 1'b0; a_win = 1'b0;
        check("prio_count", a_count, 64'h00);
        check("prio_best",  a_best,  64'h05);

        // Saturate mode
        seen = 1'b0;
        b_inc = 1'b1;
        repeat (99) begin tick(); seen = seen | b_co; end
        check("b_99_count", b_count, 64'h99);
        repeat (6) begin tick(); seen = seen | b_co; end
        b_inc = 1'b0;
        check("b_hold_count", b_count, 64'h99);
        check("b_no_carry",   seen,    64'h0);
        check("b_ovf",        b_ovf,   64'h1);
        check("b_seg",        b_seg,   {S9, S9});
        b_win = 1'b1; tick(); b_win = 1'b0;
        check("b_win_count", b_count, 64'h00);
        check("b_win_ovf",   b_ovf,   64'h0);
        check("b_win_bv",    b_bv,    64'h0);
        check("b_win_best",  b_best,  64'h00);

        // Four digits, no best tracking: triple ripple 0999 -> 1000
        c_inc = 1'b1;
        repeat (999) tick();
        c_inc = 1'b0;
        check("c_0999", c_count, 64'h0999);
        c_inc = 1'b1; tick(); c_inc = 1'b0;
        check("c_1000",     c_count, 64'h1000);
        check("c_1000_seg", c_seg,   {S1, S0, S0, S0});
        check("c_carry",    c_co,    64'h0);
        c_win = 1'b1; tick(); c_win = 1'b0;
        check("c_win_count", c_count, 64'h0000);
        check("c_best",      c_best,  64'h0000);
        check("c_bv",        c_bv,    64'h0);
        check("c_ovf",       c_ovf,   64'h0);

        // Reset beats inc; then a zero-count win is a legal capture
        a_pulses(4);
        reset = 1'b1; a_inc = 1'b1;
        tick();
        reset = 1'b0; a_inc = 1'b0;
        check("rstinc_count", a_count, 64'h00);
        check("rstinc_bv",    a_bv,    64'h0);
        check("rstinc_best",  a_best,  64'h00);
        a_winp();
        check("zero_win_bv",   a_bv,   64'h1);
        check("zero_win_best", a_best, 64'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
